// File: rtl/pq_access_arbiter.sv
// rtl/pq_access_arbiter.sv - round-robin arbiter sharing the priority-queue command port
// Two requesters, one strobe per grant, with full/empty rejection and an ack watchdog.
module pq_access_arbiter #(
  parameter int          DW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [1:0]    op,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [1:0]    err_code,
  output logic [DW-1:0] rdata,
  output logic          pq_enq,
  output logic          pq_deq,
  output logic [DW-1:0] pq_din,
  input  logic [DW-1:0] pq_dout,
  input  logic          pq_ack,
  input  logic          pq_full,
  input  logic          pq_empty,
  output logic          arb_busy,
  output logic [7:0]    op_count
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_W   = 8'(TIMEOUT);
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FULL    = 2'b01;
  localparam logic [1:0] ERR_EMPTY   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          op_q, op_d;
  logic [DW-1:0] din_q, din_d;
  logic [1:0]    err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    wd_q, wd_d;
  logic          ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic          win_one;
  logic          rej_full;
  logic          rej_empty;

  // op_q: 0 = enqueue, 1 = dequeue, latched from the winner at grant
  assign rej_full  = ~op_q & pq_full;
  assign rej_empty = op_q & pq_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      din_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= '0;
      wd_q    <= '0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      din_q   <= din_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wd_q    <= wd_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    din_d   = din_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wd_d    = wd_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    win_one = 1'b0;
    case (state_q)
      S_IDLE: begin
        // requester 1 wins if it is alone, or on a tie when the pointer favours it
        win_one = req[1] & (~req[0] | ptr_q);
        if (req != 2'b00) begin
          gnt_d   = win_one ? 2'b10 : 2'b01;
          op_d    = op[win_one];
          din_d   = win_one ? din1 : din0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rej_full) begin
          err_d   = ERR_FULL;
          state_d = S_RESP;
        end else if (rej_empty) begin
          err_d   = ERR_EMPTY;
          state_d = S_RESP;
        end else begin
          wd_d    = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + 8'd1;
        if (pq_ack) begin
          err_d   = ERR_OK;
          if (op_q) rdata_d = pq_dout;
          state_d = S_RESP;
        end else if (wd_q + 8'd1 == TIMEOUT_W) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (err_q == ERR_OK) cnt_d = cnt_q + 8'd1;
        ptr_d   = gnt_q[0];
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pq_enq   = 1'b0;
    pq_deq   = 1'b0;
    done     = 2'b00;
    err_code = ERR_OK;
    if (state_q == S_ISSUE && !rej_full && !rej_empty) begin
      pq_enq = ~op_q;
      pq_deq = op_q;
    end
    if (state_q == S_RESP) begin
      done     = gnt_q;
      err_code = err_q;
    end
  end

  assign gnt      = gnt_q;
  assign rdata    = rdata_q;
  assign pq_din   = din_q;
  assign arb_busy = (state_q != S_IDLE);
  assign op_count = cnt_q;

endmodule

// File: doc/pq_access_arbiter.md
Name: pq_access_arbiter

Overview:
- Shares the single command port of the priority-queue core between two requesters:
  - requester 0: the debounced/single-pulsed push-button path;
  - requester 1: an automatic traffic/test generator.
- Arbitrates round-robin and issues exactly one enqueue or dequeue strobe per grant.
- Waits for the core's completion pulse, then returns the dequeued data and a status code to the granted requester.
- Blocks illegal operations (enqueue when full, dequeue when empty) before they reach the core, and guards against a hung core with a watchdog.

Parameters:
- DW, 8, width of a queue entry (key and value packed) on all data ports.
- TIMEOUT, 255, cycles waited in WAIT for pq_ack before aborting; must be ≥1 and fit in 8 bits.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; one clock domain, asynchronous and active-low (0 = reset).
- req, input, 2, per-requester request; bit i belongs to requester i.
- op, input, 2, per-requester operation: 0 = enqueue, 1 = dequeue.
- din0, input, DW, requester 0 enqueue data.
- din1, input, DW, requester 1 enqueue data.
- gnt, output, 2, one-hot grant.
- done, output, 2, one-cycle completion pulse to the granted requester.
- err_code, output, 2, status valid with done: 00 ok, 01 rejected-full, 10 rejected-empty, 11 timeout.
- rdata, output, DW, dequeued entry, valid with done on a successful dequeue.
- pq_enq, output, 1, one-cycle enqueue strobe to the core.
- pq_deq, output, 1, one-cycle dequeue strobe to the core.
- pq_din, output, DW, enqueue data to the core, stable from ISSUE through WAIT.
- pq_dout, input, DW, core output, valid while pq_ack = 1.
- pq_ack, input, 1, one-cycle core completion pulse.
- pq_full, input, 1, core full flag.
- pq_empty, input, 1, core empty flag.
- arb_busy, output, 1, high in every state except IDLE.
- op_count, output, 8, count of successful operations; wraps 255 → 0.

Behaviour:
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE; the reject path is ISSUE → RESP.
- Reset (rst = 0, any state, takes effect immediately):
  - state = IDLE;
  - gnt, done, err_code, rdata, pq_enq, pq_deq, pq_din, op_count all 0;
  - round-robin pointer = 0, so requester 0 wins the first tie;
  - watchdog counter = 0.
- IDLE:
  - no req bit set → stay.
  - one bit set → grant it.
  - both bits set → grant the requester the pointer favours.
  - On grant: register the winner into gnt, latch its op and din, go to ISSUE.
- ISSUE (one cycle), checked in this order:
  - op = enqueue and pq_full = 1 → err = 01, no strobe, go to RESP.
  - op = dequeue and pq_empty = 1 → err = 10, no strobe, go to RESP.
  - otherwise → assert pq_enq or pq_deq for this cycle only, drive pq_din, clear watchdog, go to WAIT.
- WAIT:
  - watchdog increments every cycle.
  - pq_ack = 1 → capture pq_dout into rdata (dequeue only; an enqueue leaves rdata unchanged), err = 00, go to RESP.
  - watchdog reaches TIMEOUT with no ack → err = 11, go to RESP.
  - If ack and timeout coincide, ack wins.
- RESP (one cycle):
  - done[winner] = 1 and err_code driven.
  - op_count increments only when err = 00.
  - Pointer moves to the other requester.
  - gnt clears on exit; go to IDLE.
- Grant duration: gnt is held from ISSUE through RESP.
  - done and err_code are 0 outside RESP.
  - rdata holds its last value.
- Latency, counted from the IDLE cycle in which req is sampled (cycle 0):
  - strobe in cycle 1;
  - done one cycle after pq_ack;
  - rejected operation: done in cycle 2.
- Requester inputs:
  - Deasserting req after grant does not abort; done still pulses.
  - op and din are latched at grant, so later changes are ignored.
  - A requester holding req high is regranted no sooner than the IDLE cycle after RESP, and only after a waiting peer is served.
- A pq_ack outside WAIT is ignored.
- At most one of pq_enq and pq_deq is ever high.

Test Plan:
- Reset, then req = 01, op = 0, din0 = 0x35, pq_ack 3 cycles after the strobe:
  - pq_enq is high exactly 1 cycle, pq_din = 0x35;
  - done = 01 with err_code = 00 the cycle after ack;
  - op_count = 1.
- req = 11 held continuously, both enqueue, ack 1 cycle after each strobe:
  - grants alternate 01, 10, 01, 10;
  - no requester is starved;
  - the first grant goes to requester 0.
- pq_empty = 1, requester 1 dequeues:
  - no pq_deq;
  - done = 10 with err_code = 10 in cycle 2;
  - op_count unchanged.
- pq_full = 1, requester 0 enqueues:
  - no strobe;
  - err_code = 01.
- Dequeue with pq_dout = 0xA7 on ack: rdata = 0xA7 with done.
- TIMEOUT = 4, pq_ack never arrives:
  - err_code = 11 after 4 WAIT cycles, then IDLE;
  - a late ack is ignored.
- rst driven low during WAIT:
  - all outputs 0 immediately;
  - after release, a req = 10 is granted normally with pointer = 0.
